banner_ctrl: RTL and testbench
==============================

# banner_ctrl

Sequencer for the on-screen text banner: reveals a message typewriter-style, one glyph slot at a time, holds it, blinks it, then clears it.
All state advances only on the per-frame tick.
Per pixel, it tells the shared bank of glyph renderers which character slot the current pixel belongs to, and that slot's top-left corner (the renderers' start_x/start_y).
It sits between the VGA sync/pixel counter and the glyph renderer bank.

## Interface
Parameters:
- BASE_X, 200: x of slot 0 top-left.
- BASE_Y, 220: y of all slots' top-left.
- PITCH, 32: slot spacing in pixels. Must be a power of two; the 26-px glyph plus 6-px gap.
- GLYPH_H, 40: glyph height in pixels.
- MAX_LEN, 8: maximum message length in slots.
- REVEAL_FRAMES, 4: frames per revealed character.
- HOLD_FRAMES, 60: frames fully shown before blinking.
- BLINK_FRAMES, 15: frames per blink half-period.
- BLINKS, 3: number of off/on blink cycles.

Ports:
- clk  in  1  pixel clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at the start of vertical blank.
- start  in  1  one-cycle pulse that launches the banner.
- abort  in  1  one-cycle pulse that cancels the banner immediately.
- msg_len  in  4  message length in slots, sampled on an accepted start.
- x  in  10  current pixel x.
- y  in  10  current pixel y.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a full sequence completes.
- visible_count  out  4  number of slots currently revealed.
- blink_on  out  1  blink phase; 1 means visible.
- slot_en  out  1  the current pixel lies in a visible slot.
- slot_idx  out  3  slot index of the current pixel.
- slot_start_x  out  10  left edge of that slot.
- slot_start_y  out  10  top edge of that slot.

## Operation
- States are IDLE, REVEAL, HOLD and BLINK.
- An 8-bit frame counter frame_cnt counts frame_tick pulses within a state or phase. It clears on every state change.
- **IDLE**
  - On start: latch len = min(msg_len, MAX_LEN).
  - If len is 0: pulse done next cycle and remain in IDLE.
  - Otherwise: go to REVEAL with visible_count=0 and blink_on=1.
- **REVEAL**
  - Every REVEAL_FRAMES-th tick, visible_count increments.
  - On the tick where visible_count becomes len, go to HOLD.
- **HOLD**
  - After HOLD_FRAMES ticks, go to BLINK.
- **BLINK**
  - blink_on toggles every BLINK_FRAMES ticks, with the first toggle taking it to 0.
  - On the 2*BLINKS-th toggle (blink_on back at 1), go to IDLE, clear visible_count to 0 and pulse done for one cycle.
- **Start, abort and simultaneous events**
  - start while busy is ignored.
  - abort, from any state: go to IDLE next cycle with visible_count=0 and blink_on=1. No done pulse.
  - abort together with start: abort wins.
  - start together with frame_tick in IDLE: start is accepted; that tick is not counted.
- **Pixel lookup (1-cycle registered pipeline)**
  - dx = x − BASE_X.
  - slot_idx = dx >> log2(PITCH), truncated to 3 bits.
  - slot_start_x = BASE_X + slot_idx*PITCH.
  - slot_start_y = BASE_Y.
  - slot_en = 1 only when all of the following hold:
    - BASE_Y ≤ y < BASE_Y+GLYPH_H
    - BASE_X ≤ x < BASE_X + len*PITCH
    - slot_idx < visible_count
    - blink_on = 1
  - When x < BASE_X: slot_en=0, and slot_idx/slot_start_x still update but are don't-care.
  - Comparisons use 11-bit unsigned arithmetic, so BASE_X + len*PITCH can reach 200+256 without wrap.
- Gap pixels (slot x-offsets 26..31) have slot_en=1. The glyph renderer outputs 0 there.

## Timing
- Reset values:
  - State IDLE, frame_cnt 0, len 0.
  - busy 0, done 0, visible_count 0, blink_on 1.
  - slot_en 0, slot_idx 0, slot_start_x 0, slot_start_y 0.
- busy rises the cycle after an accepted start. It falls in the same cycle that done pulses.
- State and counter outputs change only in the cycle after a frame_tick, except on start, abort and reset.
- Pixel outputs lag x/y by exactly 1 cycle. They use the visible_count/blink_on values registered in the same cycle.
- Full sequence length: len*REVEAL_FRAMES + HOLD_FRAMES + 2*BLINKS*BLINK_FRAMES ticks. done pulses 1 cycle after the final tick.
- Reset asserted mid-sequence: all outputs return to reset values on the next edge. No done pulse.

## Test plan
- Reset, then start with msg_len=3 under default parameters:
  - visible_count=1 after tick 4 and 3 after tick 12, entering HOLD.
  - First blink_on=0 after tick 87.
  - done pulses after tick 162, with busy=0 in that same cycle.
- msg_len=12 → len clamped to 8; visible_count stops at 8. msg_len=0 → done pulses 1 cycle after start, busy stays 0.
- visible_count=2, x=237, y=225 → next cycle slot_en=1, slot_idx=1, slot_start_x=232, slot_start_y=220. Same with x=270 (slot 2) → slot_en=0.
- Pixel edge cases → slot_en=0:
  - y=260 (bottom edge excluded).
  - x=199.
  - blink_on=0 during BLINK at any x/y.
- start during HOLD → ignored, counters unaffected. abort+start in the same cycle during REVEAL → IDLE, visible_count=0, no done.
- Reset asserted at tick 50 → all outputs at reset values next cycle. A new start then runs the full sequence from visible_count=0.

Source files
------------

// File: rtl/banner_ctrl.sv
// Banner sequencer: typewriter reveal, hold, blink, clear.
// Also maps each pixel to its glyph slot for the renderer bank.
module banner_ctrl #(
  parameter int BASE_X        = 200,
  parameter int BASE_Y        = 220,
  parameter int PITCH         = 32,
  parameter int GLYPH_H       = 40,
  parameter int MAX_LEN       = 8,
  parameter int REVEAL_FRAMES = 4,
  parameter int HOLD_FRAMES   = 60,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINKS        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] msg_len,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       busy,
  output logic       done,
  output logic [3:0] visible_count,
  output logic       blink_on,
  output logic       slot_en,
  output logic [2:0] slot_idx,
  output logic [9:0] slot_start_x,
  output logic [9:0] slot_start_y
);

  localparam int SH = $clog2(PITCH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REVEAL = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_BLINK  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  frame_cnt;
  logic [3:0]  len;
  logic [3:0]  tgl;
  logic [3:0]  len_n;
  logic [10:0] xe;
  logic [10:0] ye;
  logic [10:0] dx;
  logic [10:0] lim;
  logic [2:0]  idx;
  logic [9:0]  sx;
  logic        x_in;
  logic        y_in;

  assign busy  = (state != S_IDLE);
  assign len_n = (msg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : msg_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      frame_cnt     <= 8'd0;
      len           <= 4'd0;
      tgl           <= 4'd0;
      done          <= 1'b0;
      visible_count <= 4'd0;
      blink_on      <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        frame_cnt     <= 8'd0;
        tgl           <= 4'd0;
        visible_count <= 4'd0;
        blink_on      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            // a tick coinciding with start is not counted
            if (start) begin
              len       <= len_n;
              frame_cnt <= 8'd0;
              tgl       <= 4'd0;
              if (len_n == 4'd0) begin
                done <= 1'b1;
              end else begin
                state         <= S_REVEAL;
                visible_count <= 4'd0;
                blink_on      <= 1'b1;
              end
            end
          end
          S_REVEAL: begin
            if (frame_tick) begin
              if (frame_cnt == 8'(REVEAL_FRAMES - 1)) begin
                frame_cnt     <= 8'd0;
                visible_count <= visible_count + 4'd1;
                if (visible_count + 4'd1 == len) state <= S_HOLD;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          S_HOLD: begin
            if (frame_tick) begin
              if (frame_cnt == 8'(HOLD_FRAMES - 1)) begin
                frame_cnt <= 8'd0;
                state     <= S_BLINK;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          S_BLINK: begin
            if (frame_tick) begin
              if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt <= 8'd0;
                blink_on  <= ~blink_on;
                tgl       <= tgl + 4'd1;
                if (tgl == 4'(2 * BLINKS - 1)) begin
                  state         <= S_IDLE;
                  tgl           <= 4'd0;
                  visible_count <= 4'd0;
                  done          <= 1'b1;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // 11-bit math so the right limit (up to BASE_X+256) never wraps
  assign xe   = {1'b0, x};
  assign ye   = {1'b0, y};
  assign dx   = xe - 11'(BASE_X);
  assign idx  = 3'(dx >> SH);
  assign sx   = 10'(BASE_X) + (10'(idx) << SH);
  assign lim  = 11'(BASE_X) + (11'(len) << SH);
  assign x_in = (xe >= 11'(BASE_X)) && (xe < lim);
  assign y_in = (ye >= 11'(BASE_Y)) &&
                (ye < 11'(BASE_Y + GLYPH_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_en      <= 1'b0;
      slot_idx     <= 3'd0;
      slot_start_x <= 10'd0;
      slot_start_y <= 10'd0;
    end else begin
      slot_idx     <= idx;
      slot_start_x <= sx;
      slot_start_y <= 10'(BASE_Y);
      slot_en      <= x_in && y_in && blink_on &&
                      ({1'b0, idx} < visible_count);
    end
  end

endmodule

// File: tb/tb_banner_ctrl.sv
// Randomized bench for banner_ctrl against a tick-count reference model.
// Directed scenarios cover the sequence timeline and pixel edges.
module tb_banner_ctrl;

  localparam int BX = 200;
  localparam int BY = 220;
  localparam int GH = 40;
  localparam int ML = 8;
  localparam int RF = 4;
  localparam int HF = 60;
  localparam int BF = 15;
  localparam int BL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       abort;
  logic [3:0] msg_len;
  logic [9:0] x;
  logic [9:0] y;
  logic       busy;
  logic       done;
  logic [3:0] visible_count;
  logic       blink_on;
  logic       slot_en;
  logic [2:0] slot_idx;
  logic [9:0] slot_start_x;
  logic [9:0] slot_start_y;

  banner_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .abort         (abort),
    .msg_len       (msg_len),
    .x             (x),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .visible_count (visible_count),
    .blink_on      (blink_on),
    .slot_en       (slot_en),
    .slot_idx      (slot_idx),
    .slot_start_x  (slot_start_x),
    .slot_start_y  (slot_start_y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: elapsed ticks since the sequence was launched
  int m_busy = 0;
  int m_t    = 0;
  int m_len  = 0;
  int m_done = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int total();
    return m_len * RF + HF + 2 * BL * BF;
  endfunction

  function automatic int e_vc();
    if (m_busy == 0) return 0;
    return (m_t / RF < m_len) ? m_t / RF : m_len;
  endfunction

  function automatic int e_blink();
    if (m_busy == 0) return 1;
    if (m_t < m_len * RF + HF) return 1;
    return (((m_t - m_len * RF - HF) / BF) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic step(input bit r, input bit tk, input bit st,
                      input bit ab, input int ml,
                      input int px, input int py);
    int dxm, e_idx, e_sx, e_en, l;
    bit pchk, poschk;
    reset = r; frame_tick = tk; start = st; abort = ab;
    msg_len = 4'(ml); x = 10'(px); y = 10'(py);
    dxm   = (px + 2048 - BX) % 2048;
    e_idx = (dxm / 32) % 8;
    e_sx  = (BX + e_idx * 32) % 1024;
    e_en  = (py >= BY && py < BY + GH && px >= BX &&
             px < BX + m_len * 32 && e_idx < e_vc() &&
             e_blink() == 1) ? 1 : 0;
    pchk   = !tk && !st && !ab;
    poschk = px >= BX;
    @(posedge clk);
    m_done = 0;
    if (r) begin
      m_busy = 0; m_t = 0; m_len = 0;
    end else if (ab) begin
      m_busy = 0; m_t = 0;
    end else if (m_busy == 0) begin
      if (st) begin
        l = (ml > ML) ? ML : ml;
        m_len = l;
        m_t = 0;
        if (l == 0) m_done = 1;
        else m_busy = 1;
      end
    end else if (tk) begin
      m_t++;
      if (m_t == total()) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("visible_count", visible_count, e_vc());
    chk("blink_on", blink_on, e_blink());
    if (r) begin
      chk("rst_slot_en", slot_en, 0);
      chk("rst_slot_idx", slot_idx, 0);
      chk("rst_start_x", slot_start_x, 0);
      chk("rst_start_y", slot_start_y, 0);
    end else if (pchk) begin
      chk("slot_en", slot_en, e_en);
      chk("start_y", slot_start_y, BY);
      if (poschk) begin
        chk("slot_idx", slot_idx, e_idx);
        chk("start_x", slot_start_x, e_sx);
      end
    end
  endtask

  task automatic idle(input int px, input int py);
    step(0, 0, 0, 0, 0, px, py);
  endtask

  task automatic rnd_idle();
    idle($urandom_range(180, 480), $urandom_range(210, 270));
  endtask

  task automatic tick();
    step(0, 1, 0, 0, 0, $urandom_range(180, 480), $urandom_range(210, 270));
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rnd_idle();
    end
  endtask

  initial begin
    reset = 1; frame_tick = 0; start = 0; abort = 0;
    msg_len = 0; x = 0; y = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_blink", blink_on, 1);

    // full default sequence, len 3
    step(0, 0, 1, 0, 3, 0, 0);
    chk("start_busy", busy, 1);
    for (int n = 1; n <= 162; n++) begin
      tick();
      if (n == 4) chk("vc_at_4", visible_count, 1);
      if (n == 11) chk("vc_at_11", visible_count, 2);
      if (n == 12) chk("vc_at_12", visible_count, 3);
      if (n == 86) chk("blink_at_86", blink_on, 1);
      if (n == 87) chk("blink_at_87", blink_on, 0);
      if (n == 162) begin
        chk("done_at_162", done, 1);
        chk("busy_at_162", busy, 0);
      end
      if (n == 9) begin
        idle(237, 225);
        chk("px_en", slot_en, 1);
        chk("px_idx", slot_idx, 1);
        chk("px_sx", slot_start_x, 232);
        chk("px_sy", slot_start_y, 220);
        idle(270, 225);
        chk("px_slot2", slot_en, 0);
        idle(237, 260);
        chk("px_y260", slot_en, 0);
        idle(199, 225);
        chk("px_x199", slot_en, 0);
      end else if (n == 88) begin
        idle(237, 225);
        chk("px_blink_off", slot_en, 0);
      end else begin
        rnd_idle();
      end
    end
    rnd_idle();
    chk("done_drop", done, 0);

    // clamp to MAX_LEN
    step(0, 0, 1, 0, 12, 0, 0);
    run_ticks(36);
    chk("clamp_vc", visible_count, 8);
    step(0, 0, 0, 1, 0, 0, 0);

    // zero-length message
    step(0, 0, 1, 0, 0, 0, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    rnd_idle();

    // start in HOLD is ignored
    step(0, 0, 1, 0, 1, 0, 0);
    run_ticks(10);
    step(0, 0, 1, 0, 5, 0, 0);
    chk("hold_start_vc", visible_count, 1);
    chk("hold_start_busy", busy, 1);
    run_ticks(2);

    // abort with start in REVEAL
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 6, 0, 0);
    run_ticks(9);
    step(0, 0, 1, 1, 6, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_vc", visible_count, 0);
    chk("abort_done", done, 0);
    rnd_idle();

    // reset mid-sequence then a clean full run
    step(0, 0, 1, 0, 3, 0, 0);
    run_ticks(50);
    step(1, 0, 0, 0, 0, 237, 225);
    chk("mid_rst_vc", visible_count, 0);
    chk("mid_rst_en", slot_en, 0);
    step(0, 0, 1, 0, 3, 0, 0);
    run_ticks(161);
    tick();
    chk("rerun_done", done, 1);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      step(($urandom % 1500) == 0, ($urandom % 3) == 0,
           ($urandom % 25) == 0, ($urandom % 800) == 0,
           $urandom % 16, $urandom_range(180, 480),
           $urandom_range(210, 270));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
